// File: rtl/icache_pkg.sv
// Shared types and helpers for the N-way instruction cache.
// Optional feature macro: ICACHE_PERF_CNT_EN (hit/miss counters in icache_nway).
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS,
    S_REFILL,
    S_UNC,
    S_FLUSH
  } state_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int index_w(input int sets);
    return clog2(sets);
  endfunction

  // Byte offset inside a line: word select bits plus the 2 byte bits.
  function automatic int offs_w(input int line_words);
    return clog2(line_words) + 2;
  endfunction

  // Way number width, at least one bit so WAYS=1 still has a legal vector.
  function automatic int way_w(input int ways);
    return (ways > 1) ? clog2(ways) : 1;
  endfunction

  // Geometry of the default build (2-way, 128 sets, 8-word lines).
  localparam int DEF_INDEX_W = index_w(128);
  localparam int DEF_OFFS_W  = offs_w(8);
  localparam int DEF_TAG_W   = 32 - DEF_INDEX_W - DEF_OFFS_W;

endpackage

// File: rtl/icache_plru.sv
// Per-set tree pseudo-LRU state (WAYS-1 bits per set) for 1, 2 or 4 ways.
// A set's tree bits point away from the most recently touched way; the
// victim is found by following the bits from the root.
module icache_plru
  import icache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      touch_en,
  input  logic [way_w(WAYS)-1:0]    touch_way,
  input  logic [index_w(SETS)-1:0]  set,
  output logic [way_w(WAYS)-1:0]    victim_way
);

  generate
    if (WAYS == 1) begin : g_direct
      logic unused_plru;
      assign unused_plru = ^{clk, rst, clear, touch_en, touch_way, set};
      assign victim_way  = '0;
    end else begin : g_tree
      logic [WAYS-2:0] bits_q [SETS];
      logic [WAYS-2:0] cur;
      logic [WAYS-2:0] upd;

      if (WAYS == 2) begin : g_two
        // Single bit: victim is the way the bit names; touching points it at the other way.
        always_comb begin
          cur        = bits_q[set];
          upd        = cur;
          victim_way = cur[0];
          upd[0]     = ~touch_way[0];
        end
      end else begin : g_four
        // Root bit selects the pair, leaf bits select the way inside each pair.
        always_comb begin
          cur        = bits_q[set];
          upd        = cur;
          victim_way = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};
          upd[0]     = ~touch_way[1];
          if (touch_way[1]) upd[2] = ~touch_way[0];
          else              upd[1] = ~touch_way[0];
        end
      end

      // Tree bits: cleared by reset or flush, updated on every touch.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
        end else if (clear) begin
          for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
        end else if (touch_en) begin
          bits_q[set] <= upd;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/icache_nway.sv
// Blocking N-way set-associative VIPT instruction cache with tree-PLRU
// replacement, uncached bypass and whole-cache flush.
// Optional feature macro: ICACHE_PERF_CNT_EN adds saturating hit/miss counters.
module icache_nway
  import icache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [31:0]             vaddr_i,
  input  logic [31:0]             paddr_i,
  input  logic                    uncached_i,
  input  logic                    flush_i,
  output logic                    resp_valid_o,
  output logic [31:0]             inst_o,
  output logic                    hit_o,
  output logic                    mem_req_o,
  output logic [31:0]             mem_addr_o,
  output logic                    mem_uncached_o,
  input  logic                    mem_valid_i,
  input  logic [32*LINE_WORDS-1:0] mem_data_i
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o
`endif
);

  localparam int INDEX_W = index_w(SETS);
  localparam int OFFS_W  = offs_w(LINE_WORDS);
  localparam int TAG_W   = 32 - INDEX_W - OFFS_W;
  localparam int WAY_W   = way_w(WAYS);
  localparam int LINE_W  = 32 * LINE_WORDS;

  // Picks the 32-bit word addressed by addr out of a line.
  function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line, input logic [31:0] addr);
    int k;
    k = int'((addr >> 2) & 32'(LINE_WORDS - 1));
    return line[32*k +: 32];
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  state_e                state_q, state_d;
  logic                  flush_pend_q;
  logic [INDEX_W-1:0]    flush_cnt_q;
  logic [WAYS-1:0]       valid_q [SETS];

  logic [31:0]           paddr_q;
  logic [INDEX_W-1:0]    idx_q;
  logic [LINE_W-1:0]     line_q;

  logic [TAG_W-1:0]      tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0]     data_mem [WAYS][SETS];
  logic [TAG_W-1:0]      rd_tag   [WAYS];
  logic [LINE_W-1:0]     rd_data  [WAYS];

  logic                  accept;
  logic                  rd_en;
  logic [INDEX_W-1:0]    rd_idx;
  logic [WAYS-1:0]       hit_vec;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [LINE_W-1:0]     hit_line;
  logic [WAY_W-1:0]      plru_victim;
  logic [WAY_W-1:0]      victim_way;
  logic                  touch_en;
  logic [WAY_W-1:0]      touch_way;
  logic                  unused_vaddr;

  // Index comes from the virtual address; only the index bits are needed.
  assign rd_idx       = vaddr_i[INDEX_W+OFFS_W-1:OFFS_W];
  assign unused_vaddr = ^{vaddr_i[31:INDEX_W+OFFS_W], vaddr_i[OFFS_W-1:0]};
  assign accept       = req_valid_i && req_ready_o;
  assign rd_en        = accept && !uncached_i;

  // Tag compare against every way; at most one way can match since a tag is only ever filled on a miss.
  always_comb begin
    hit_way  = '0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[idx_q][w] && (rd_tag[w] == paddr_q[31:32-TAG_W]);
      if (hit_vec[w]) begin
        hit_way  = WAY_W'(w);
        hit_line = rd_data[w];
      end
    end
    hit = |hit_vec;
  end

  // Refill victim: lowest-numbered invalid way, otherwise the PLRU choice.
  always_comb begin
    victim_way = plru_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx_q][w]) victim_way = WAY_W'(w);
    end
  end

  assign touch_en  = (state_q == S_LOOKUP && hit) || (state_q == S_REFILL);
  assign touch_way = (state_q == S_REFILL) ? victim_way : hit_way;

  icache_plru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_q == S_FLUSH),
    .touch_en   (touch_en),
    .touch_way  (touch_way),
    .set        (idx_q),
    .victim_way (plru_victim)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic and state-decoded handshake outputs; flush outranks a new request.
  always_comb begin
    state_d        = state_q;
    req_ready_o    = 1'b0;
    mem_req_o      = 1'b0;
    mem_uncached_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = !flush_pend_q && !flush_i;
        if (flush_i || flush_pend_q) state_d = S_FLUSH;
        else if (req_valid_i)        state_d = uncached_i ? S_UNC : S_LOOKUP;
      end
      S_LOOKUP: state_d = hit ? S_IDLE : S_MISS;
      S_MISS: begin
        mem_req_o = 1'b1;
        if (mem_valid_i) state_d = S_REFILL;
      end
      S_REFILL: state_d = S_IDLE;
      S_UNC: begin
        mem_req_o      = 1'b1;
        mem_uncached_o = 1'b1;
        if (mem_valid_i) state_d = S_IDLE;
      end
      S_FLUSH: begin
        if (flush_cnt_q == INDEX_W'(SETS - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control flops: pending flush, flush sweep counter, valid bits, bridge address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_pend_q <= 1'b0;
      flush_cnt_q  <= '0;
      mem_addr_o   <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      if (state_q == S_IDLE)                         flush_pend_q <= 1'b0;
      else if (flush_i && state_q != S_FLUSH)        flush_pend_q <= 1'b1;

      flush_cnt_q <= (state_q == S_FLUSH) ? flush_cnt_q + 1'b1 : '0;

      if (state_q == S_FLUSH)  valid_q[flush_cnt_q] <= '0;
      if (state_q == S_REFILL) valid_q[idx_q][victim_way] <= 1'b1;

      if (accept) mem_addr_o <= uncached_i ? {paddr_i[31:2], 2'b00}
                                           : {paddr_i[31:OFFS_W], {OFFS_W{1'b0}}};
    end
  end

  // Response register: one-cycle pulse from a hit, a completed refill or an uncached return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_o <= 1'b0;
      inst_o       <= '0;
      hit_o        <= 1'b0;
    end else begin
      resp_valid_o <= 1'b0;
      hit_o        <= 1'b0;
      case (state_q)
        S_LOOKUP: if (hit) begin
          resp_valid_o <= 1'b1;
          hit_o        <= 1'b1;
          inst_o       <= word_sel(hit_line, paddr_q);
        end
        S_REFILL: begin
          resp_valid_o <= 1'b1;
          inst_o       <= word_sel(line_q, paddr_q);
        end
        S_UNC: if (mem_valid_i) begin
          resp_valid_o <= 1'b1;
          inst_o       <= mem_data_i[31:0];
        end
        default: ;
      endcase
    end
  end

  // Request capture and refill line latch.
  always_ff @(posedge clk) begin
    if (accept) begin
      paddr_q <= paddr_i;
      idx_q   <= rd_idx;
    end
    if (state_q == S_MISS && mem_valid_i) line_q <= mem_data_i;
  end

  // Tag/data arrays: synchronous read at acceptance, write of the victim way on refill.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        rd_tag[w]  <= tag_mem[w][rd_idx];
        rd_data[w] <= data_mem[w][rd_idx];
      end
    end
    if (state_q == S_REFILL) begin
      tag_mem[victim_way][idx_q]  <= paddr_q[31:32-TAG_W];
      data_mem[victim_way][idx_q] <= line_q;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Saturating event counters; uncached fetches are counted as misses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (state_q == S_LOOKUP && hit) hit_cnt_o <= sat_inc(hit_cnt_o);
      if ((state_q == S_LOOKUP && !hit) || (state_q == S_UNC && mem_valid_i))
        miss_cnt_o <= sat_inc(miss_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Self-checking bench for icache_nway (default 2-way, 128 sets, 8-word lines).
// Reference model: per-set list of resident tags in recency order.
module tb_icache_nway;

  logic         clk;
  logic         rst;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [31:0]  vaddr_i;
  logic [31:0]  paddr_i;
  logic         uncached_i;
  logic         flush_i;
  logic         resp_valid_o;
  logic [31:0]  inst_o;
  logic         hit_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_uncached_o;
  logic         mem_valid_i;
  logic [255:0] mem_data_i;

  int checks;
  int errors;

  // Model state: up to two resident tags per set, index 0 = most recent.
  logic [19:0] res_tag [128][2];
  int          nres    [128];

  icache_nway dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .vaddr_i        (vaddr_i),
    .paddr_i        (paddr_i),
    .uncached_i     (uncached_i),
    .flush_i        (flush_i),
    .resp_valid_o   (resp_valid_o),
    .inst_o         (inst_o),
    .hit_o          (hit_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_uncached_o (mem_uncached_o),
    .mem_valid_i    (mem_valid_i),
    .mem_data_i     (mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Backing memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [255:0] make_line(input logic [31:0] base, input logic unc);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) begin
      if (unc) l[32*k +: 32] = (k == 0) ? mem_word(base) : $urandom;
      else     l[32*k +: 32] = mem_word(base + 32'(4 * k));
    end
    return l;
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < 128; s++) nres[s] = 0;
  endfunction

  // Returns whether the access hits, and updates recency / residency.
  function automatic bit model_access(input logic [31:0] pa, input logic unc);
    int          s;
    logic [19:0] t;
    s = int'(pa[11:5]);
    t = pa[31:12];
    if (unc) return 1'b0;
    for (int i = 0; i < nres[s]; i++) begin
      if (res_tag[s][i] == t) begin
        for (int j = i; j > 0; j--) res_tag[s][j] = res_tag[s][j-1];
        res_tag[s][0] = t;
        return 1'b1;
      end
    end
    if (nres[s] < 2) nres[s] = nres[s] + 1;
    for (int j = nres[s] - 1; j > 0; j--) res_tag[s][j] = res_tag[s][j-1];
    res_tag[s][0] = t;
    return 1'b0;
  endfunction

  task automatic wait_ready(input int limit);
    int n;
    n = 0;
    while (!req_ready_o && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) chk("ready_timeout", {31'd0, req_ready_o}, 32'd1);
  endtask

  task automatic do_flush();
    wait_ready(400);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    model_flush();
    wait_ready(400);
  endtask

  // mode 0: plain fetch; 1: pulse flush_i while the miss is outstanding;
  // 2: assert reset while the miss is outstanding.
  task automatic fetch(input logic [31:0] pa, input logic unc, input int mode);
    bit          exp_hit, seen, sent, done;
    logic [31:0] exp_addr, r;
    int          cyc, dly, wcnt;
    exp_hit  = model_access(pa, unc);
    exp_addr = unc ? {pa[31:2], 2'b00} : {pa[31:5], 5'b00000};
    wait_ready(400);
    r           = $urandom;
    req_valid_i = 1'b1;
    vaddr_i     = {r[31:12], pa[11:0]};
    paddr_i     = pa;
    uncached_i  = unc;
    @(negedge clk);
    req_valid_i = 1'b0;
    cyc  = 1;
    dly  = $urandom_range(0, 3);
    wcnt = 0;
    seen = 1'b0;
    sent = 1'b0;
    done = 1'b0;
    while (!done && cyc < 100) begin
      if (resp_valid_o) begin
        done = 1'b1;
      end else begin
        if (mem_req_o) begin
          if (!seen) begin
            seen = 1'b1;
            chk("mem_addr", mem_addr_o, exp_addr);
            chk("mem_uncached", {31'd0, mem_uncached_o}, {31'd0, unc});
            if (mode == 1) flush_i = 1'b1;
            if (mode == 2) begin
              rst = 1'b0;
              #1;
              chk("rst_mid_ready", {31'd0, req_ready_o}, 32'd1);
              chk("rst_mid_resp_valid", {31'd0, resp_valid_o}, 32'd0);
              chk("rst_mid_inst", inst_o, 32'd0);
              chk("rst_mid_hit", {31'd0, hit_o}, 32'd0);
              chk("rst_mid_mem_req", {31'd0, mem_req_o}, 32'd0);
              chk("rst_mid_mem_addr", mem_addr_o, 32'd0);
              @(negedge clk);
              rst = 1'b1;
              model_flush();
              return;
            end
          end
          if (!sent && wcnt == dly) begin
            mem_valid_i = 1'b1;
            mem_data_i  = make_line(exp_addr, unc);
            sent        = 1'b1;
          end
          wcnt++;
        end
        @(negedge clk);
        cyc++;
        flush_i     = 1'b0;
        mem_valid_i = 1'b0;
      end
    end
    chk("resp_seen", {31'd0, done}, 32'd1);
    if (done) begin
      chk("inst", inst_o, mem_word(pa));
      chk("hit", {31'd0, hit_o}, {31'd0, exp_hit});
      chk("mem_req_seen", {31'd0, seen}, {31'd0, !exp_hit});
      if (exp_hit) chk("hit_latency", 32'(cyc), 32'd2);
    end
  endtask

  initial begin
    int          n;
    logic [31:0] rtag, ridx, rword, pa;
    logic [19:0] tags [4];
    checks      = 0;
    errors      = 0;
    tags[0]     = 20'h1C000;
    tags[1]     = 20'h2A000;
    tags[2]     = 20'h3B000;
    tags[3]     = 20'h4C000;
    rst         = 1'b0;
    req_valid_i = 1'b0;
    vaddr_i     = '0;
    paddr_i     = '0;
    uncached_i  = 1'b0;
    flush_i     = 1'b0;
    mem_valid_i = 1'b0;
    mem_data_i  = '0;
    model_flush();
    repeat (3) @(negedge clk);

    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_hit", {31'd0, hit_o}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss then hit on the same line.
    do_flush();
    fetch(32'h1C00_0040, 1'b0, 0);
    fetch(32'h1C00_0044, 1'b0, 0);

    // Set 2 replacement: A resident, fill B, touch A, miss C evicts B.
    fetch(32'h2A00_0040, 1'b0, 0);
    fetch(32'h1C00_0048, 1'b0, 0);
    fetch(32'h3B00_004C, 1'b0, 0);
    fetch(32'h1C00_0050, 1'b0, 0);
    fetch(32'h2A00_0054, 1'b0, 0);

    // Uncached fetches never allocate.
    fetch(32'hBFC0_0008, 1'b1, 0);
    fetch(32'hBFC0_0008, 1'b1, 0);

    // Flush requested during a miss: refill completes, then a full sweep.
    fetch(32'h4C00_0060, 1'b0, 1);
    n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("flush_ready_low_cycles", 32'(n), 32'd128);
    model_flush();
    fetch(32'h4C00_0064, 1'b0, 0);

    // Reset during a miss wipes the cache.
    fetch(32'h1C00_0040, 1'b0, 0);
    fetch(32'h1C00_0044, 1'b0, 0);
    fetch(32'h2A00_0060, 1'b0, 2);
    fetch(32'h1C00_0044, 1'b0, 0);
    fetch(32'h4C00_0064, 1'b0, 0);

    // Randomised traffic over a small address pool to mix hits, misses and evictions.
    for (int it = 0; it < 300; it++) begin
      rtag  = 32'($urandom_range(0, 3));
      ridx  = 32'($urandom_range(2, 3));
      rword = 32'($urandom_range(0, 7));
      pa    = {tags[rtag], ridx[6:0], rword[2:0], 2'b00};
      if ($urandom_range(0, 39) == 0) do_flush();
      fetch(pa, ($urandom_range(0, 7) == 0), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
